// File: rtl/icache_refill_pkg.sv
// Shared types and widths for the instruction cache refill block.
// Address bus width, byte counter width and refill FSM states.
package icache_refill_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int BYTE_CNT_W  = 2;
    localparam int WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITG,
        S_ISSUE,
        S_DRAIN,
        S_WB
    } state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction cache miss handler: fetches a 4-byte word from the
// byte-wide memory, writes it into the icache and returns it to IF.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              hit_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    input  logic              mem_grant_i,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_din_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       winst_o,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic              busy_o
);

    state_e                      state_q;
    logic [ADDR_W-1:0]           base_q;
    logic [BYTE_CNT_W-1:0]       cnt_q;
    logic [WORD_BYTES-1:0][7:0]  bytes_q;
    logic                        killed_q;

    logic                        in_req;
    logic                        in_wb;
    logic [ADDR_W-1:0]           base_d;

    // Word-aligned base of the missing fetch address.
    assign base_d = addr_i & ~ADDR_W'(3);

    // Output decodes of the registered state.
    assign in_req = (state_q == S_WAITG) || (state_q == S_ISSUE);
    assign in_wb  = (state_q == S_WB);

    assign mem_req_o    = in_req;
    // Byte offset only ever lands in bits [1:0]: no carry upward.
    assign mem_a_o      = in_req ? (base_q | ADDR_W'(cnt_q)) : '0;
    assign we_o         = in_wb;
    assign waddr_o      = in_wb ? base_q : '0;
    assign winst_o      = in_wb ? bytes_q : '0;
    assign inst_o       = in_wb ? bytes_q : '0;
    assign inst_valid_o = in_wb & ~killed_q & ~flush_i;
    assign busy_o       = (state_q != S_IDLE);

    // Refill FSM: request burst, byte capture and write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            bytes_q  <= '0;
            killed_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req_i && !hit_i && !flush_i) begin
                        base_q   <= base_d;
                        killed_q <= 1'b0;
                        state_q  <= S_WAITG;
                    end
                end
                S_WAITG: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (mem_grant_i) begin
                        cnt_q   <= BYTE_CNT_W'(1);
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Data of the previously accepted address arrives now.
                    bytes_q[cnt_q - 2'd1] <= mem_din_i;
                    if (flush_i) begin
                        killed_q <= 1'b1;
                    end
                    if (cnt_q == 2'd3) begin
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    bytes_q[3] <= mem_din_i;
                    if (flush_i) begin
                        killed_q <= 1'b1;
                    end
                    state_q <= S_WB;
                end
                S_WB: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: bench-side RAM and arbiter,
// expected writes and byte addresses queued by stimulus, checked by a monitor.
module tb_icache_refill;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic [31:0] addr_i;
    logic        hit_i;
    logic        flush_i;
    logic        mem_req_o;
    logic        mem_grant_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_din_i;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] winst_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        busy_o;

    icache_refill #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .hit_i        (hit_i),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_grant_i  (mem_grant_i),
        .mem_a_o      (mem_a_o),
        .mem_din_i    (mem_din_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .winst_o      (winst_o),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] w;
        bit          v;
    } wb_t;

    wb_t         wb_q[$];
    logic [31:0] addr_q[$];
    logic [7:0]  ram_pre[logic [31:0]];
    logic [7:0]  salt;
    int          cyc;
    int          nvec;
    int          nerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rb(input logic [31:0] a);
        if (ram_pre.exists(a)) return ram_pre[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ salt;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] b);
        return {rb(b + 3), rb(b + 2), rb(b + 1), rb(b)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-wide RAM: data for an accepted address appears next cycle.
    always @(posedge clk) begin
        if (mem_req_o && mem_grant_i)
            mem_din_i <= rb(mem_a_o);
        else
            mem_din_i <= 8'($urandom);
    end

    // Monitor: accepted addresses and cache writes against the queues.
    always @(negedge clk) begin
        wb_t it;
        if (mem_req_o && mem_grant_i) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_access", mem_a_o, 32'hxxxx_xxxx);
            end else begin
                chk("mem_a", mem_a_o, addr_q.pop_front());
            end
        end
        if (we_o) begin
            if (wb_q.size() == 0) begin
                chk("unexpected_we", waddr_o, 32'hxxxx_xxxx);
            end else begin
                it = wb_q.pop_front();
                chk("wb_cycle", cyc, it.cyc);
                chk("waddr", waddr_o, it.a);
                chk("winst", winst_o, it.w);
                chk("inst", inst_o, it.w);
                chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, it.v});
            end
        end else if (inst_valid_o) begin
            chk("stray_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        end
    end

    // One miss: gd grant-wait cycles, flush in cycle fl, reset in cycle rs
    // (0 = none). Cycle 0 is the cycle the miss is presented.
    task automatic miss(input logic [31:0] a, input int gd,
                        input int fl, input int rs);
        logic [31:0] b;
        wb_t         it;
        int          t0;
        int          nreq;
        int          last;
        bit          wflush;
        bit          kill;
        b      = a & 32'hFFFF_FFFC;
        wflush = (fl >= 1) && (fl <= gd + 1);
        kill   = (fl >= gd + 2) && (fl <= gd + 6);
        t0     = cyc;
        if (!wflush) begin
            for (int k = 0; k < 4; k++) addr_q.push_back(b + k);
            if (rs == 0) begin
                it.cyc = t0 + 6 + gd;
                it.a   = b;
                it.w   = word_at(b);
                it.v   = !kill;
                wb_q.push_back(it);
            end
        end
        last = wflush ? fl + 1 : (rs != 0 ? rs + 1 : gd + 7);
        req_i   = 1'b1;
        addr_i  = a;
        hit_i   = 1'b0;
        flush_i = 1'b0;
        nreq    = 0;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (c == last) begin
                req_i       = 1'b0;
                flush_i     = 1'b0;
                rst         = 1'b0;
                mem_grant_i = 1'b0;
            end else begin
                nreq += int'(mem_req_o);
                addr_i      = $urandom;
                mem_grant_i = !wflush && (c >= gd + 1) && (c <= gd + 4);
                flush_i     = (c == fl);
                rst         = (c == rs);
            end
        end
        if (wflush) begin
            chk("wflush_mem_req", {31'd0, mem_req_o}, 32'd0);
            chk("wflush_busy", {31'd0, busy_o}, 32'd0);
        end else if (rs != 0) begin
            chk("rst_outs", {29'd0, mem_req_o, we_o, inst_valid_o}, 32'd0);
            chk("rst_busy", {31'd0, busy_o}, 32'd0);
            chk("rst_mem_a", mem_a_o, 32'd0);
            chk("rst_waddr", waddr_o, 32'd0);
            chk("rst_winst", winst_o | inst_o, 32'd0);
            addr_q.delete();
        end else begin
            chk("req_cycles", nreq, gd + 4);
            chk("busy_after_wb", {31'd0, busy_o}, 32'd0);
        end
    endtask

    task automatic hit_req(input logic [31:0] a);
        req_i  = 1'b1;
        hit_i  = 1'b1;
        addr_i = a;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hit_busy", {31'd0, busy_o}, 32'd0);
            chk("hit_mem_req", {31'd0, mem_req_o}, 32'd0);
        end
        req_i = 1'b0;
        hit_i = 1'b0;
    endtask

    initial begin
        int gd;
        int mode;
        nvec        = 0;
        nerr        = 0;
        salt        = 8'($urandom);
        rst         = 1'b1;
        req_i       = 1'b0;
        addr_i      = '0;
        hit_i       = 1'b0;
        flush_i     = 1'b0;
        mem_grant_i = 1'b0;
        ram_pre[32'h0000_1004] = 8'h13;
        ram_pre[32'h0000_1005] = 8'h05;
        ram_pre[32'h0000_1006] = 8'h50;
        ram_pre[32'h0000_1007] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {29'd0, mem_req_o, we_o, inst_valid_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_mem_a", mem_a_o, 32'd0);
        chk("reset_data", waddr_o | winst_o | inst_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("known_word", word_at(32'h0000_1004), 32'h0050_0513);
        miss(32'h0000_1004, 0, 0, 0);
        miss(32'h0000_2002, 3, 0, 0);
        miss(32'h0000_3008, 0, 3, 0);
        miss(32'h0000_4000, 3, 2, 0);
        miss(32'h0000_5010, 1, 0, 0);
        hit_req(32'h0000_6000);
        miss(32'h0000_7000, 0, 0, 3);
        repeat (3) @(posedge clk);
        #1;
        miss(32'hFFFF_FFFC, 0, 0, 0);
        miss(32'h0000_8004, 2, 8, 0);

        for (int n = 0; n < 60; n++) begin
            gd   = $urandom_range(0, 3);
            mode = $urandom_range(0, 6);
            case (mode)
                0: miss($urandom, gd, $urandom_range(1, gd + 1), 0);
                1: miss($urandom, gd, $urandom_range(gd + 2, gd + 6), 0);
                2: hit_req($urandom);
                3: miss($urandom, gd, 0, $urandom_range(gd + 1, gd + 5));
                default: miss($urandom, gd, 0, 0);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        for (int w = 0; w < 20 && (wb_q.size() + addr_q.size()) != 0; w++)
            @(posedge clk);
        #1;
        chk("pending_writes", wb_q.size(), 0);
        chk("pending_addrs", addr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
